// File: rtl/clock_pkg.sv
// Shared timekeeping types, time constants and the alarm channel state encoding
// used by multi_alarm_m and alarm_channel_m.
package clock_pkg;

    typedef logic [16:0] counter_t;
    typedef logic        flag_t;

    localparam int COUNTER_MAX_DEFAULT = 86399;
    localparam int SEC_PER_MIN         = 60;
    localparam int SEC_PER_HOUR        = 3600;
    localparam int SEC_PER_HALF_DAY    = 43200;

    typedef enum logic [1:0] {
        CH_DISABLED = 2'd0,
        CH_ARMED    = 2'd1,
        CH_RINGING  = 2'd2,
        CH_SNOOZED  = 2'd3
    } chan_state_e;

    // Seconds-of-day increment with wrap back to midnight after max.
    function automatic counter_t wrap_inc(input counter_t value, input counter_t max);
        return (value >= max) ? '0 : counter_t'(value + counter_t'(1));
    endfunction

endpackage

// File: rtl/alarm_channel_m.sv
// One alarm channel: setpoint register plus arm/ring state machine. With
// MULTI_ALARM_SNOOZE_EN defined it also has the SNOOZED state and down-counter.
module alarm_channel_m
    import clock_pkg::*;
#(
    parameter int SNOOZE_SEC = 540
) (
    input  logic     clock,
    input  logic     reset_n,
    input  logic     wr_i,
    input  logic     wr_en_i,
    input  counter_t wr_time_i,
    input  logic     ack_i,
`ifdef MULTI_ALARM_SNOOZE_EN
    input  logic     snooze_i,
`endif
    input  logic     tick_i,
    input  counter_t next_count_i,
    output logic     ringing_o
);

    chan_state_e state_q, state_d;
    counter_t    setpoint_q, setpoint_d;
    logic        match;

    // Only the post-increment value of a real tick can match, so sets never ring.
    assign match = tick_i && (next_count_i == setpoint_q);

`ifdef MULTI_ALARM_SNOOZE_EN
    localparam int SNZ_W = $clog2(SNOOZE_SEC + 1);
    logic [SNZ_W-1:0] snz_q, snz_d;
`else
    localparam int snooze_sec_unused = SNOOZE_SEC;
`endif

    always_comb begin
        state_d    = state_q;
        setpoint_d = setpoint_q;
`ifdef MULTI_ALARM_SNOOZE_EN
        snz_d      = snz_q;
`endif
        if (wr_i) begin
            setpoint_d = wr_time_i;
            state_d    = wr_en_i ? CH_ARMED : CH_DISABLED;
`ifdef MULTI_ALARM_SNOOZE_EN
            snz_d      = '0;
`endif
        end else if (ack_i) begin
            if (state_q == CH_RINGING || state_q == CH_SNOOZED) begin
                state_d = CH_ARMED;
`ifdef MULTI_ALARM_SNOOZE_EN
                snz_d   = '0;
`endif
            end
`ifdef MULTI_ALARM_SNOOZE_EN
        end else if (snooze_i && state_q == CH_RINGING) begin
            state_d = CH_SNOOZED;
            snz_d   = SNZ_W'(SNOOZE_SEC);
`endif
        end else begin
            case (state_q)
                CH_ARMED: begin
                    if (match) begin
                        state_d = CH_RINGING;
                    end
                end
`ifdef MULTI_ALARM_SNOOZE_EN
                // Expiry happens on the tick that brings the count to zero.
                CH_SNOOZED: begin
                    if (tick_i) begin
                        if (snz_q <= SNZ_W'(1)) begin
                            snz_d   = '0;
                            state_d = CH_RINGING;
                        end else begin
                            snz_d = snz_q - SNZ_W'(1);
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CH_DISABLED;
            setpoint_q <= '0;
        end else begin
            state_q    <= state_d;
            setpoint_q <= setpoint_d;
        end
    end

`ifdef MULTI_ALARM_SNOOZE_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snz_q <= '0;
        end else begin
            snz_q <= snz_d;
        end
    end
`endif

    assign ringing_o = (state_q == CH_RINGING);

endmodule

// File: rtl/multi_alarm_m.sv
// Seconds-of-day timekeeper with N_ALARMS programmable alarm channels.
// Define MULTI_ALARM_SNOOZE_EN to enable per-channel snooze.
module multi_alarm_m
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int COUNTER_MAX   = COUNTER_MAX_DEFAULT,
    parameter int N_ALARMS      = 4,
    parameter int SNOOZE_SEC    = 540
) (
    input  logic                                           clock,
    input  logic                                           reset_n,
    input  logic                                           set_flag,
    input  counter_t                                       set_time,
    input  logic                                           alarm_wr,
    input  logic [$clog2(N_ALARMS > 1 ? N_ALARMS : 2)-1:0] alarm_idx,
    input  counter_t                                       alarm_time,
    input  logic                                           alarm_en,
    input  logic [N_ALARMS-1:0]                            ack,
    input  logic [N_ALARMS-1:0]                            snooze,
    output counter_t                                       counter_state,
    output flag_t                                          sec_pulse,
    output logic [N_ALARMS-1:0]                            alarm_state,
    output flag_t                                          alarm_any
);

    localparam int       IDX_W    = $clog2(N_ALARMS > 1 ? N_ALARMS : 2);
    localparam int       PRE_W    = $clog2(TICKS_PER_SEC > 1 ? TICKS_PER_SEC : 2);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);
    localparam counter_t CNT_MAX  = counter_t'(COUNTER_MAX);

    logic [PRE_W-1:0] prescale_q, prescale_d;
    counter_t         counter_q, counter_d;
    flag_t            sec_pulse_q;
    flag_t            tick;

    assign tick = !set_flag && (prescale_q == PRE_LAST);

    // A set holds the prescaler at zero so the first tick lands a full second after release.
    always_comb begin
        prescale_d = prescale_q + PRE_W'(1);
        counter_d  = counter_q;
        if (set_flag) begin
            prescale_d = '0;
            if (set_time <= CNT_MAX) begin
                counter_d = set_time;
            end
        end else if (tick) begin
            prescale_d = '0;
            counter_d  = wrap_inc(counter_q, CNT_MAX);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prescale_q  <= '0;
            counter_q   <= '0;
            sec_pulse_q <= 1'b0;
        end else begin
            prescale_q  <= prescale_d;
            counter_q   <= counter_d;
            sec_pulse_q <= tick;
        end
    end

    assign counter_state = counter_q;
    assign sec_pulse     = sec_pulse_q;

`ifndef MULTI_ALARM_SNOOZE_EN
    logic [N_ALARMS-1:0] snooze_unused;
    assign snooze_unused = snooze;
`endif

    // Indices at or above N_ALARMS select no channel, so such writes vanish.
    for (genvar g = 0; g < N_ALARMS; g++) begin : g_chan
        logic wr_sel;
        assign wr_sel = alarm_wr && (alarm_idx == IDX_W'(g));

        alarm_channel_m #(
            .SNOOZE_SEC (SNOOZE_SEC)
        ) u_chan (
            .clock        (clock),
            .reset_n      (reset_n),
            .wr_i         (wr_sel),
            .wr_en_i      (alarm_en),
            .wr_time_i    (alarm_time),
            .ack_i        (ack[g]),
`ifdef MULTI_ALARM_SNOOZE_EN
            .snooze_i     (snooze[g]),
`endif
            .tick_i       (tick),
            .next_count_i (counter_d),
            .ringing_o    (alarm_state[g])
        );
    end

    assign alarm_any = |alarm_state;

endmodule

// File: tb/tb_multi_alarm_m.sv
// Directed self-checking bench for multi_alarm_m with TICKS_PER_SEC=2,
// N_ALARMS=4, SNOOZE_SEC=3; snooze scenario runs when MULTI_ALARM_SNOOZE_EN is defined.
module tb_multi_alarm_m;

    logic        clock;
    logic        reset_n;
    logic        set_flag;
    logic [16:0] set_time;
    logic        alarm_wr;
    logic [1:0]  alarm_idx;
    logic [16:0] alarm_time;
    logic        alarm_en;
    logic [3:0]  ack;
    logic [3:0]  snooze;
    logic [16:0] counter_state;
    logic        sec_pulse;
    logic [3:0]  alarm_state;
    logic        alarm_any;

    int checksTotal  = 0;
    int checksPassed = 0;

    multi_alarm_m #(
        .TICKS_PER_SEC (2),
        .COUNTER_MAX   (86399),
        .N_ALARMS      (4),
        .SNOOZE_SEC    (3)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .set_flag      (set_flag),
        .set_time      (set_time),
        .alarm_wr      (alarm_wr),
        .alarm_idx     (alarm_idx),
        .alarm_time    (alarm_time),
        .alarm_en      (alarm_en),
        .ack           (ack),
        .snooze        (snooze),
        .counter_state (counter_state),
        .sec_pulse     (sec_pulse),
        .alarm_state   (alarm_state),
        .alarm_any     (alarm_any)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Every comparison goes through here so the pass/total counts stay honest.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checksTotal++;
        if (observed === expected) begin
            checksPassed++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives one full set of inputs at a falling edge, then waits for the next falling edge.
    task automatic applyStimulus(input logic sf, input logic [16:0] st, input logic wr,
                                 input logic [1:0] idx, input logic [16:0] at, input logic en,
                                 input logic [3:0] ak, input logic [3:0] sn);
        set_flag   = sf;
        set_time   = st;
        alarm_wr   = wr;
        alarm_idx  = idx;
        alarm_time = at;
        alarm_en   = en;
        ack        = ak;
        snooze     = sn;
        @(negedge clock);
    endtask

    task automatic holdCycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    initial begin
        reset_n    = 1'b0;
        set_flag   = 1'b0;
        set_time   = '0;
        alarm_wr   = 1'b0;
        alarm_idx  = '0;
        alarm_time = '0;
        alarm_en   = 1'b0;
        ack        = '0;
        snooze     = '0;

        // Reset state and free-running count up to 17.
        @(negedge clock);
        checkOutput("rst_counter", counter_state, 0);
        checkOutput("rst_pulse", sec_pulse, 0);
        checkOutput("rst_alarm", alarm_state, 0);
        checkOutput("rst_any", alarm_any, 0);
        reset_n = 1'b1;
        holdCycles(34);
        checkOutput("count_17", counter_state, 17);
        checkOutput("pulse_at_17", sec_pulse, 1);

        // Asynchronous reset mid-count.
        #2 reset_n = 1'b0;
        #1;
        checkOutput("async_rst_counter", counter_state, 0);
        checkOutput("async_rst_pulse", sec_pulse, 0);
        @(negedge clock);
        reset_n = 1'b1;
        holdCycles(1);
        checkOutput("post_rst_c1", counter_state, 0);
        checkOutput("post_rst_p1", sec_pulse, 0);
        holdCycles(1);
        checkOutput("post_rst_c2", counter_state, 1);
        checkOutput("post_rst_p2", sec_pulse, 1);
        holdCycles(1);
        checkOutput("post_rst_p3", sec_pulse, 0);

        // Set near midnight, hold, release and watch the wrap.
        applyStimulus(1, 17'd86398, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            checkOutput("set_hold_cnt", counter_state, 86398);
            checkOutput("set_hold_pulse", sec_pulse, 0);
            holdCycles(1);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rel_c0", counter_state, 86398);
        checkOutput("rel_p0", sec_pulse, 0);
        holdCycles(1);
        checkOutput("rel_c1", counter_state, 86399);
        checkOutput("rel_p1", sec_pulse, 1);
        holdCycles(1);
        checkOutput("rel_p1_low", sec_pulse, 0);
        holdCycles(1);
        checkOutput("wrap_c", counter_state, 0);
        checkOutput("wrap_p", sec_pulse, 1);
        holdCycles(2);
        checkOutput("after_wrap_c", counter_state, 1);

        // Out-of-range set value leaves the counter alone.
        applyStimulus(1, 17'd100000, 0, 0, 0, 0, 0, 0);
        checkOutput("set_oob", counter_state, 1);

        // Channel 2 programmed at 34955 rings only on the tick to 34961.
        applyStimulus(1, 17'd34955, 0, 0, 0, 0, 0, 0);
        checkOutput("set_34955", counter_state, 34955);
        applyStimulus(0, 0, 1, 2'd2, 17'd34961, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        holdCycles(9);
        checkOutput("ch2_pre_cnt", counter_state, 34960);
        checkOutput("ch2_pre_alarm", alarm_state, 0);
        holdCycles(1);
        checkOutput("ch2_ring_cnt", counter_state, 34961);
        checkOutput("ch2_ring", alarm_state, 4'b0100);
        checkOutput("ch2_any", alarm_any, 1);
        holdCycles(1);
        checkOutput("ch2_still_ring", alarm_state, 4'b0100);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0100, 0);
        checkOutput("ch2_ack", alarm_state, 0);
        checkOutput("ch2_ack_any", alarm_any, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // A set value equal to the setpoint must not ring; a set just before it must.
        applyStimulus(1, 17'd50925, 1, 2'd0, 17'd50925, 1, 0, 0);
        applyStimulus(1, 17'd50925, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        holdCycles(3);
        checkOutput("ch0_noring_cnt", counter_state, 50927);
        checkOutput("ch0_noring", alarm_state, 0);
        applyStimulus(1, 17'd50924, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ch0_pre", alarm_state, 0);
        holdCycles(1);
        checkOutput("ch0_ring_cnt", counter_state, 50925);
        checkOutput("ch0_ring", alarm_state, 4'b0001);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0001, 0);
        checkOutput("ch0_ack", alarm_state, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Disabling ch3 on its match edge wins; ch1 with the same setpoint still rings.
        applyStimulus(1, 17'd59998, 1, 2'd3, 17'd60000, 1, 0, 0);
        applyStimulus(1, 17'd59998, 1, 2'd1, 17'd60000, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        holdCycles(2);
        checkOutput("dis_pre_cnt", counter_state, 59999);
        applyStimulus(0, 0, 1, 2'd3, 17'd60000, 0, 0, 0);
        checkOutput("dis_cnt", counter_state, 60000);
        checkOutput("dis_ch3_off", alarm_state, 4'b0010);

        // Reset while ringing clears everything immediately.
        #2 reset_n = 1'b0;
        #1;
        checkOutput("ring_rst_alarm", alarm_state, 0);
        checkOutput("ring_rst_any", alarm_any, 0);
        checkOutput("ring_rst_cnt", counter_state, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;

`ifdef MULTI_ALARM_SNOOZE_EN
        // Snooze for 3 ticks re-rings at 103; ack while snoozed returns to ARMED.
        applyStimulus(1, 17'd99, 1, 2'd1, 17'd100, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        holdCycles(1);
        checkOutput("snz_ring100", alarm_state, 4'b0010);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b0010);
        checkOutput("snz_quiet", alarm_state, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        holdCycles(3);
        checkOutput("snz_102_cnt", counter_state, 102);
        checkOutput("snz_102", alarm_state, 0);
        holdCycles(1);
        checkOutput("snz_103_cnt", counter_state, 103);
        checkOutput("snz_rering", alarm_state, 4'b0010);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 4'b0010);
        checkOutput("snz_again", alarm_state, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0010, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        holdCycles(7);
        checkOutput("snz_ack_cnt", counter_state, 108);
        checkOutput("snz_ack_norering", alarm_state, 0);
`endif

        $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule
